// File: rtl/coherent_bus_ctrl_if.sv
// Bundle of request, snoop, memory and response signals between the snooping bus controller
// and the attached caches/memory.
interface coherent_bus_ctrl_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
);
  localparam int unsigned SRC_W = $clog2(NUM_CORES);

  // per-core requests
  logic [NUM_CORES-1:0]        req;
  logic [2*NUM_CORES-1:0]      req_type;
  logic [NUM_CORES*ADDR_W-1:0] req_addr;
  logic [NUM_CORES*DATA_W-1:0] req_data;
  logic [NUM_CORES-1:0]        gnt;

  // snoop broadcast and replies
  logic                        snoop_valid;
  logic [1:0]                  snoop_type;
  logic [ADDR_W-1:0]           snoop_addr;
  logic [SRC_W-1:0]            snoop_src;
  logic [NUM_CORES-1:0]        snoop_hit;
  logic [NUM_CORES-1:0]        snoop_dirty;
  logic [NUM_CORES*DATA_W-1:0] snoop_data;

  // memory port
  logic                        mem_req;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_ack;
  logic [DATA_W-1:0]           mem_rdata;

  // response
  logic [NUM_CORES-1:0]        resp_valid;
  logic [DATA_W-1:0]           resp_data;
  logic                        resp_shared;
  logic                        coh_err;

  modport master (
    input  req, req_type, req_addr, req_data,
    input  snoop_hit, snoop_dirty, snoop_data,
    input  mem_ack, mem_rdata,
    output gnt,
    output snoop_valid, snoop_type, snoop_addr, snoop_src,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output resp_valid, resp_data, resp_shared, coh_err
  );

  modport slave (
    output req, req_type, req_addr, req_data,
    output snoop_hit, snoop_dirty, snoop_data,
    output mem_ack, mem_rdata,
    input  gnt,
    input  snoop_valid, snoop_type, snoop_addr, snoop_src,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  resp_valid, resp_data, resp_shared, coh_err
  );
endinterface

// File: rtl/coherent_bus_ctrl.sv
// Snooping coherence bus controller: round-robin arbitration, one-cycle snoop broadcast,
// dirty-owner intervention with memory write-back, and a single-cycle response.
module coherent_bus_ctrl #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  coherent_bus_ctrl_if.master  bus
);
  localparam int unsigned SRC_W = $clog2(NUM_CORES);

  localparam logic [1:0] TypeRdMs = 2'b00;
  localparam logic [1:0] TypeWrMs = 2'b01;
  localparam logic [1:0] TypeWrBk = 2'b10;

  localparam logic [NUM_CORES-1:0] OneHot0 = {{(NUM_CORES-1){1'b0}}, 1'b1};
  localparam logic [SRC_W:0]       NumCoresW = (SRC_W+1)'(NUM_CORES);
  localparam logic [SRC_W-1:0]     LastCore  = SRC_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSnoop,
    StMemRd,
    StMemWr,
    StResp
  } state_e;

  state_e               state_q, state_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]     src_q, src_d;
  logic [1:0]           type_q, type_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [NUM_CORES-1:0] gnt_q, gnt_d;
  logic                 shared_q, shared_d;
  logic                 coh_err_q, coh_err_d;

  // Round-robin pick: first requester at or above rr_ptr, wrapping.
  logic             req_found;
  logic [SRC_W-1:0] req_idx;
  logic [SRC_W:0]   cand;
  logic [1:0]       req_type_sel;

  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
      if (cand >= NumCoresW) cand = cand - NumCoresW;
      if (!req_found && bus.req[cand[SRC_W-1:0]]) begin
        req_found = 1'b1;
        req_idx   = cand[SRC_W-1:0];
      end
    end
  end

  assign req_type_sel = bus.req_type[req_idx*2 +: 2];

  // Snoop replies with the requester's own bits masked off.
  logic [NUM_CORES-1:0] src_oh;
  logic [NUM_CORES-1:0] hit_m;
  logic [NUM_CORES-1:0] dirty_m;
  logic [SRC_W-1:0]     owner_idx;
  logic [DATA_W-1:0]    owner_data;
  logic                 multi_dirty;

  assign src_oh      = OneHot0 << src_q;
  assign hit_m       = bus.snoop_hit & ~src_oh;
  assign dirty_m     = bus.snoop_dirty & ~src_oh;
  assign multi_dirty = |(dirty_m & (dirty_m - OneHot0));

  // Downward scan so the lowest dirty index wins.
  always_comb begin
    owner_idx = '0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (dirty_m[i]) owner_idx = SRC_W'(i);
    end
  end

  assign owner_data = bus.snoop_data[owner_idx*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    src_d     = src_q;
    type_d    = type_q;
    addr_d    = addr_q;
    data_d    = data_q;
    gnt_d     = gnt_q;
    shared_d  = shared_q;
    coh_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_found) begin
          src_d    = req_idx;
          type_d   = req_type_sel;
          addr_d   = bus.req_addr[req_idx*ADDR_W +: ADDR_W];
          data_d   = bus.req_data[req_idx*DATA_W +: DATA_W];
          gnt_d    = OneHot0 << req_idx;
          shared_d = 1'b0;
          unique case (req_type_sel)
            TypeRdMs, TypeWrMs: state_d = StSnoop;
            TypeWrBk:           state_d = StMemWr;
            default:            state_d = StResp;
          endcase
        end
      end
      StSnoop: begin
        shared_d  = (type_q == TypeRdMs) && (|hit_m);
        coh_err_d = multi_dirty;
        if (!(|dirty_m)) begin
          state_d = StMemRd;
        end else begin
          // Owner supplies the line; a read also writes it back to memory.
          data_d  = owner_data;
          state_d = (type_q == TypeRdMs) ? StMemWr : StResp;
        end
      end
      StMemRd: begin
        if (bus.mem_ack) begin
          data_d  = bus.mem_rdata;
          state_d = StResp;
        end
      end
      StMemWr: begin
        if (bus.mem_ack) state_d = StResp;
      end
      StResp: begin
        state_d  = StIdle;
        gnt_d    = '0;
        rr_ptr_d = (src_q == LastCore) ? '0 : src_q + SRC_W'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      src_q     <= '0;
      type_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      gnt_q     <= '0;
      shared_q  <= 1'b0;
      coh_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      src_q     <= src_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      gnt_q     <= gnt_d;
      shared_q  <= shared_d;
      coh_err_q <= coh_err_d;
    end
  end

  logic in_snoop, in_mem, in_resp;

  assign in_snoop = (state_q == StSnoop);
  assign in_mem   = (state_q == StMemRd) || (state_q == StMemWr);
  assign in_resp  = (state_q == StResp);

  assign bus.gnt         = gnt_q;
  assign bus.snoop_valid = in_snoop;
  assign bus.snoop_type  = in_snoop ? type_q : '0;
  assign bus.snoop_addr  = in_snoop ? addr_q : '0;
  assign bus.snoop_src   = in_snoop ? src_q : '0;

  assign bus.mem_req   = in_mem;
  assign bus.mem_we    = (state_q == StMemWr);
  assign bus.mem_addr  = in_mem ? addr_q : '0;
  assign bus.mem_wdata = (state_q == StMemWr) ? data_q : '0;

  // Write-backs and reserved requests return no data.
  assign bus.resp_valid  = in_resp ? src_oh : '0;
  assign bus.resp_data   = (in_resp && !type_q[1]) ? data_q : '0;
  assign bus.resp_shared = shared_q;
  assign bus.coh_err     = coh_err_q;

endmodule

// File: tb/tb_coherent_bus_ctrl.sv
// Scoreboard bench for coherent_bus_ctrl: behavioural cache-snoop and memory responders,
// expected responses queued at request time and compared when resp_valid fires.
module tb_coherent_bus_ctrl;
  localparam int unsigned NC = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coherent_bus_ctrl_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) bus ();

  coherent_bus_ctrl #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Responders: caches answer only while the snoop is broadcast.
  logic [NC-1:0]    cfg_hit = '0;
  logic [NC-1:0]    cfg_dirty = '0;
  logic [NC*DW-1:0] cfg_data = '0;
  logic [DW-1:0]    cfg_rdata = '0;
  logic             ack_en = 1'b1;
  logic             ack_force = 1'b0;

  assign bus.snoop_hit   = bus.snoop_valid ? cfg_hit : '0;
  assign bus.snoop_dirty = bus.snoop_valid ? cfg_dirty : '0;
  assign bus.snoop_data  = cfg_data;
  assign bus.mem_ack     = (bus.mem_req & ack_en) | ack_force;
  assign bus.mem_rdata   = cfg_rdata;

  int          mem_rd_cnt = 0;
  int          mem_wr_cnt = 0;
  int          coh_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  always @(negedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_ack) begin
      if (bus.mem_we) begin
        mem_wr_cnt <= mem_wr_cnt + 1;
        wr_addr    <= bus.mem_addr;
        wr_data    <= bus.mem_wdata;
      end else begin
        mem_rd_cnt <= mem_rd_cnt + 1;
      end
    end
    if (bus.coh_err) coh_cnt <= coh_cnt + 1;
  end

  typedef struct packed {
    logic [NC-1:0] vld;
    logic [DW-1:0] data;
    logic          shared;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int core, input logic [DW-1:0] data, input logic shared);
    exp_t e;
    e.vld    = NC'(1) << core;
    e.data   = data;
    e.shared = shared;
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check_eq("resp_valid", bus.resp_valid, e.vld);
      check_eq("resp_data", bus.resp_data, e.data);
      check_eq("resp_shared", bus.resp_shared, e.shared);
    end
  endtask

  task automatic drive_req(input int core, input logic [1:0] typ, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    bus.req_type[core*2 +: 2]  = typ;
    bus.req_addr[core*AW +: AW] = addr;
    bus.req_data[core*DW +: DW] = wdata;
    bus.req[core]               = 1'b1;
  endtask

  // One transaction, checking grant, snoop contents, latency and the queued response.
  task automatic run_txn(input int core, input logic [1:0] typ, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data,
                         input logic exp_shared, input int exp_lat);
    int cyc;
    int snoops;
    push_exp(core, exp_data, exp_shared);
    @(negedge clk);
    drive_req(core, typ, addr, wdata);
    @(posedge clk);
    #1;
    check_eq("gnt", bus.gnt, NC'(1) << core);
    cyc    = 0;
    snoops = 0;
    while (cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (bus.snoop_valid) begin
        snoops++;
        check_eq("snoop_addr", bus.snoop_addr, addr);
        check_eq("snoop_src", bus.snoop_src, core);
        check_eq("snoop_type", bus.snoop_type, typ);
      end
      if (bus.resp_valid != '0) break;
    end
    check_eq("latency", cyc, exp_lat);
    check_eq("snoop_count", snoops, (typ == 2'b00 || typ == 2'b01) ? 1 : 0);
    if (bus.resp_valid != '0) pop_compare();
    bus.req[core] = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input bit release_req);
    int cyc;
    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid != '0) begin
        if (release_req) bus.req = bus.req & ~bus.resp_valid;
        pop_compare();
      end
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic clear_cfg();
    cfg_hit   = '0;
    cfg_dirty = '0;
    cfg_data  = '0;
  endtask

  int rd0, wr0, coh0, cyc;

  initial begin
    bus.req      = '0;
    bus.req_type = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_gnt", bus.gnt, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_snoop_valid", bus.snoop_valid, 0);
    check_eq("rst_coh_err", bus.coh_err, 0);

    // All four requesters held from reset: grants rotate 0,1,2,3,0.
    cfg_rdata = 32'h1234;
    for (int c = 0; c < int'(NC); c++) push_exp(c, 32'h1234, 1'b0);
    push_exp(0, 32'h1234, 1'b0);
    for (int c = 0; c < int'(NC); c++) drive_req(c, 2'b00, AW'(32'h1000 + c * 4), '0);
    drain(1'b0);
    bus.req = '0;
    @(negedge clk);

    // Clean read miss.
    cfg_rdata = 32'hCAFE;
    rd0 = mem_rd_cnt;
    run_txn(2, 2'b00, 32'h100, '0, 32'hCAFE, 1'b0, 3);
    check_eq("clean_mem_rd", mem_rd_cnt - rd0, 1);

    // Intervention from dirty owner core1.
    cfg_hit   = 4'b0010;
    cfg_dirty = 4'b0010;
    cfg_data[1*DW +: DW] = 32'h55;
    rd0 = mem_rd_cnt; wr0 = mem_wr_cnt; coh0 = coh_cnt;
    run_txn(0, 2'b00, 32'h200, '0, 32'h55, 1'b1, 3);
    check_eq("intv_wr_cnt", mem_wr_cnt - wr0, 1);
    check_eq("intv_rd_cnt", mem_rd_cnt - rd0, 0);
    check_eq("intv_wdata", wr_data, 32'h55);
    check_eq("intv_waddr", wr_addr, 32'h200);
    check_eq("intv_coh", coh_cnt - coh0, 0);
    clear_cfg();

    // Two dirty owners on a write miss: lowest wins, error flagged, no memory traffic.
    cfg_hit   = 4'b0110;
    cfg_dirty = 4'b0110;
    cfg_data[1*DW +: DW] = 32'h11;
    cfg_data[2*DW +: DW] = 32'h22;
    rd0 = mem_rd_cnt; wr0 = mem_wr_cnt; coh0 = coh_cnt;
    run_txn(3, 2'b01, 32'h300, '0, 32'h11, 1'b0, 2);
    check_eq("dual_coh", coh_cnt - coh0, 1);
    check_eq("dual_mem", (mem_rd_cnt - rd0) + (mem_wr_cnt - wr0), 0);
    clear_cfg();

    // Requester's own dirty/hit bits must be ignored.
    cfg_hit   = 4'b0010;
    cfg_dirty = 4'b0010;
    cfg_data[1*DW +: DW] = 32'h77;
    cfg_rdata = 32'hBEEF;
    rd0 = mem_rd_cnt; wr0 = mem_wr_cnt;
    run_txn(1, 2'b00, 32'h340, '0, 32'hBEEF, 1'b0, 3);
    check_eq("mask_rd_cnt", mem_rd_cnt - rd0, 1);
    check_eq("mask_wr_cnt", mem_wr_cnt - wr0, 0);
    clear_cfg();

    // Write-back goes straight to memory and returns no data.
    wr0 = mem_wr_cnt;
    run_txn(0, 2'b10, 32'h400, 32'hD00D, '0, 1'b0, 2);
    check_eq("wrbk_wr_cnt", mem_wr_cnt - wr0, 1);
    check_eq("wrbk_wdata", wr_data, 32'hD00D);
    check_eq("wrbk_waddr", wr_addr, 32'h400);

    // Reserved type responds immediately with zero data.
    run_txn(2, 2'b11, 32'h500, 32'hFFFF, '0, 1'b0, 1);

    // Reset while a memory read is stalled.
    ack_en = 1'b0;
    cfg_rdata = 32'h9999;
    drive_req(1, 2'b00, 32'h600, '0);
    cyc = 0;
    while (!bus.mem_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("stall_mem_req", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_gnt", bus.gnt, 0);
    check_eq("arst_mem_req", bus.mem_req, 0);
    check_eq("arst_mem_addr", bus.mem_addr, 0);
    check_eq("arst_resp_valid", bus.resp_valid, 0);
    check_eq("arst_snoop_valid", bus.snoop_valid, 0);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    check_eq("late_ack_gnt", bus.gnt, 0);
    check_eq("late_ack_resp", bus.resp_valid, 0);

    push_exp(0, '0, 1'b0);
    push_exp(3, '0, 1'b0);
    drive_req(0, 2'b11, 32'h700, '0);
    drive_req(3, 2'b11, 32'h704, '0);
    @(posedge clk);
    #1;
    check_eq("post_rst_gnt", bus.gnt, 4'b0001);
    drain(1'b1);

    check_eq("sb_final", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coherent_bus_ctrl.md
COHERENT_BUS_CTRL -- requirements
Module: coherent_bus_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, meaning number of attached caches (2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock (all state on rising edge).
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, NUM_CORES, meaning per-core request, held until its resp_valid bit.
REQ-007 SHALL have port req_type, input, 2*NUM_CORES, meaning 2 bits per core: 00 RdMs, 01 WrMs, 10 WrBk, 11 reserved.
REQ-008 SHALL have ports req_addr (NUM_CORES*ADDR_W) and req_data (NUM_CORES*DATA_W), input, meaning per-core address and write-back data.
REQ-009 SHALL have port gnt, output, NUM_CORES, meaning one-hot grant held for the whole transaction.
REQ-010 SHALL have ports snoop_valid (1), snoop_type (2), snoop_addr (ADDR_W) and snoop_src ($clog2(NUM_CORES)), output, meaning the broadcast snoop.
REQ-011 SHALL have ports snoop_hit and snoop_dirty (NUM_CORES each) and snoop_data (NUM_CORES*DATA_W), input, meaning combinational snoop replies, valid while snoop_valid is high.
REQ-012 SHALL have ports mem_req, mem_we (1), mem_addr (ADDR_W) and mem_wdata (DATA_W), output; mem_ack (1) and mem_rdata (DATA_W), input.
REQ-013 SHALL have ports resp_valid (NUM_CORES, one-hot), resp_data (DATA_W), resp_shared (1) and coh_err (1), output.

Function
REQ-014 SHALL implement FSM states IDLE, SNOOP, MEM_RD, MEM_WR, RESP.
REQ-015 In IDLE with any req bit set, SHALL on the next edge grant the first requester found scanning upward from rr_ptr with wrap; SHALL latch its type, address, data and index; SHALL set gnt.
REQ-016 In that same edge, SHALL go to SNOOP for RdMs/WrMs, MEM_WR for WrBk and RESP for reserved.
REQ-017 SNOOP SHALL last exactly one cycle with snoop_valid=1 and the latched type, address and source; the source core's hit and dirty bits SHALL be masked.
REQ-018 From SNOOP: if no dirty bit is set, SHALL go to MEM_RD; if RdMs with dirty, SHALL capture the owner's data and go to MEM_WR; if WrMs with dirty, SHALL capture the owner's data and go to RESP.
REQ-019 If more than one masked dirty bit is set, SHALL use the lowest index and pulse coh_err for one cycle.
REQ-020 SHALL register resp_shared at the SNOOP exit as the OR of the masked snoop_hit bits for RdMs; it SHALL be 0 for WrMs, WrBk and reserved.
REQ-021 In MEM_RD, SHALL hold mem_req=1, mem_we=0 and mem_addr=latched address until mem_ack; on ack it SHALL capture mem_rdata and go to RESP.
REQ-022 In MEM_WR, SHALL hold mem_req=1, mem_we=1 and mem_wdata=latched or captured data until mem_ack, then go to RESP.
REQ-023 RESP SHALL last one cycle, with resp_valid[src]=1 and resp_data=captured data; resp_data SHALL be 0 for WrBk and reserved.
REQ-024 On leaving RESP, SHALL go to IDLE, clear gnt and set rr_ptr=(src+1) mod NUM_CORES.
REQ-025 Minimum latency from the sampling edge to resp_valid SHALL be: 1 cycle for reserved, 2 for WrBk and WrMs-dirty, 3 for clean miss and RdMs-dirty, with mem_ack given in the first mem cycle.
REQ-026 Any req change while not in IDLE SHALL be ignored, and the current transaction SHALL complete.
REQ-027 IDLE SHALL consume one cycle between transactions, so back-to-back grants are at least one idle cycle apart.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, rr_ptr=0, and all outputs and latched registers to 0, including mid-transaction with mem_req pending.
REQ-029 An outstanding mem_ack arriving after reset SHALL be ignored.

Verification
REQ-030 Clean read: core2 RdMs 0x100, no hits, mem_ack in first cycle, mem_rdata=0xCAFE -> gnt=0100, then resp_valid=0100 and resp_data=0xCAFE 3 cycles after the sampling edge, resp_shared=0.
REQ-031 Intervention: core0 RdMs, snoop_dirty=0010, core1 data=0x55 -> MEM_WR with wdata=0x55, then resp_data=0x55, resp_shared=1.
REQ-032 Round-robin: all four req held continuously from reset -> grant order 0,1,2,3,0.
REQ-033 Dual dirty: core3 WrMs, snoop_dirty=0110 -> core1 data used, coh_err pulses once, no memory access.
REQ-034 Reset mid-MEM_RD: rst_n low with mem_req=1 -> all outputs 0 immediately; after release, core0 is granted first.
REQ-035 Source masking: core1 RdMs with snoop_dirty=0010 and snoop_hit=0010 -> treated as clean miss, resp_shared=0.
